// File: rtl/dmac_pkg.sv
// Shared types and AHB encodings for the DMA controller.
package dmac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ACTIVE,
    DONE,
    ERROR
  } arb_state_e;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

endpackage

// File: rtl/dmac_req_arbiter_if.sv
// Peripheral request / channel control bundle of the DMA request arbiter.
interface dmac_req_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] dma_req;
  logic [NUM_REQ-1:0] dma_ack;
  logic               suspend;
  logic               chan_irq;
  logic [1:0]         M_HResp;
  logic               cfg_load;
  logic [IDX_W-1:0]   grant_idx;
  logic               channel_en;
  logic               busy;
  logic               err_irq;
  logic [IDX_W-1:0]   err_idx;
  logic [NUM_REQ-1:0] mask_clr;
  logic [NUM_REQ-1:0] err_mask;

  modport master (
    input  dma_req, suspend, chan_irq, M_HResp, mask_clr,
    output dma_ack, cfg_load, grant_idx, channel_en, busy, err_irq, err_idx, err_mask
  );

  modport slave (
    output dma_req, suspend, chan_irq, M_HResp, mask_clr,
    input  dma_ack, cfg_load, grant_idx, channel_en, busy, err_irq, err_idx, err_mask
  );

endinterface

// File: rtl/dmac_rr_picker.sv
// Find-first-set over req_i starting at start_i, wrapping modulo NUM_REQ.
module dmac_rr_picker #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] start_i,
  output logic [$clog2(NUM_REQ)-1:0] idx_o,
  output logic                       valid_o
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] rot;

  // Rotating the doubled vector puts start_i at bit 0; the lowest set bit wins.
  assign rot = NUM_REQ'({req_i, req_i} >> start_i);

  always_comb begin
    int s;
    idx_o   = '0;
    valid_o = 1'b0;
    s       = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        s = int'(start_i) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        idx_o   = IDX_W'(s);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmac_req_arbiter.sv
// DMA request arbiter: grants one peripheral at a time to the channel datapath.
// Build option DMAC_ARB_FIXED_PRIO_EN replaces round-robin with lowest-index priority.
module dmac_req_arbiter
  import dmac_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                clk,
  input  logic                rst,
  dmac_req_arbiter_if.master  bus
);
  // IDLE   | wait for an eligible request
  // LOAD   | cfg_load strobe for grant_idx
  // ACTIVE | transfer running, channel_en = ~suspend
  // DONE   | dma_ack pulse, advance pointer
  // ERROR  | err_irq pulse, mask requester, advance pointer
  localparam int IDX_W = $clog2(NUM_REQ);
  typedef logic [NUM_REQ-1:0] vec_t;

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] err_idx_q, err_idx_d;
  vec_t             err_mask_q, err_mask_d;
  vec_t             last_ack_q, last_ack_d;
  vec_t             eligible, grant_oh;
  logic [IDX_W-1:0] pick_idx, pick_start;
  logic             pick_valid;
  logic             cfg_load_c, chan_en_c, err_irq_c;
  vec_t             ack_c;

  assign eligible = bus.dma_req & ~err_mask_q & ~last_ack_q;
  assign grant_oh = vec_t'(1) << grant_q;

`ifdef DMAC_ARB_FIXED_PRIO_EN
  assign pick_start = '0;
`else
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] next_ptr;

  assign next_ptr   = (int'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + 1'b1;
  assign pick_start = rr_ptr_q;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == DONE || state_q == ERROR) rr_ptr_d = next_ptr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end
`endif

  dmac_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_i   (eligible),
    .start_i (pick_start),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      err_idx_q  <= '0;
      err_mask_q <= '0;
      last_ack_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      err_idx_q  <= err_idx_d;
      err_mask_q <= err_mask_d;
      last_ack_q <= last_ack_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    err_idx_d  = err_idx_q;
    err_mask_d = err_mask_q & ~bus.mask_clr;
    last_ack_d = '0;
    cfg_load_c = 1'b0;
    chan_en_c  = 1'b0;
    err_irq_c  = 1'b0;
    ack_c      = '0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          state_d = LOAD;
        end
      end
      LOAD: begin
        cfg_load_c = 1'b1;
        state_d    = ACTIVE;
      end
      ACTIVE: begin
        chan_en_c = ~bus.suspend;
        if (bus.M_HResp == HRESP_ERROR) state_d = ERROR;
        else if (bus.chan_irq)          state_d = DONE;
      end
      DONE: begin
        ack_c      = grant_oh;
        last_ack_d = grant_oh;
        state_d    = IDLE;
      end
      ERROR: begin
        // Applied after the clear so a coincident mask_clr loses.
        err_irq_c  = 1'b1;
        err_mask_d = err_mask_d | grant_oh;
        err_idx_d  = grant_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cfg_load   = cfg_load_c;
  assign bus.channel_en = chan_en_c;
  assign bus.dma_ack    = ack_c;
  assign bus.err_irq    = err_irq_c;
  assign bus.busy       = (state_q != IDLE);
  assign bus.grant_idx  = grant_q;
  assign bus.err_idx    = (state_q == ERROR) ? grant_q : err_idx_q;
  assign bus.err_mask   = err_mask_q;

endmodule

// File: tb/tb_dmac_req_arbiter.sv
// Self-checking bench for dmac_req_arbiter: vector table, corner sequences, random vs model.
module tb_dmac_req_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmac_req_arbiter_if #(.NUM_REQ(N)) bus ();
  dmac_req_arbiter #(.NUM_REQ(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] req;
    logic       irq;
    logic [1:0] hresp;
    logic [3:0] clr;
    logic [15:0] exp;  // {cfg, en, busy, eirq, grant[1:0], eidx[1:0], ack[3:0], emask[3:0]}
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [3:0] req, input logic irq, input logic [1:0] hresp,
                              input logic [3:0] clr, input logic cfg, input logic en,
                              input logic busy, input logic eirq, input logic [1:0] grant,
                              input logic [1:0] eidx, input logic [3:0] ack, input logic [3:0] emask);
    vec_t v;
    v.req = req; v.irq = irq; v.hresp = hresp; v.clr = clr;
    v.exp = {cfg, en, busy, eirq, grant, eidx, ack, emask};
    return v;
  endfunction

  function automatic logic [15:0] act_vec();
    return {bus.cfg_load, bus.channel_en, bus.busy, bus.err_irq, bus.grant_idx,
            bus.err_idx, bus.dma_ack, bus.err_mask};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    bus.dma_req  = '0;
    bus.suspend  = 1'b0;
    bus.chan_irq = 1'b0;
    bus.M_HResp  = 2'b00;
    bus.mask_clr = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    #1 chk("reset_outputs", act_vec(), 16'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_cfg(output int g);
    g = -1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      #1;
      if (bus.cfg_load) begin
        g = int'(bus.grant_idx);
        return;
      end
    end
    errors++;
    checks++;
    $display("FAIL wait_cfg: no cfg_load within 16 cycles at %0t", $time);
  endtask

  // Behavioural reference: transaction-level view of the arbitration rules.
  int         m_phase;   // 0 idle, 1 load, 2 active, 3 done, 4 error
  int         m_owner, m_ptr, m_last, m_eidx;
  logic [3:0] m_mask;

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_ptr = 0; m_last = -1; m_eidx = 0; m_mask = '0;
  endtask

  function automatic int first_from(input logic [3:0] set, input int start);
    for (int k = 0; k < N; k++) begin
      if (set[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [15:0] model_out();
    logic [3:0] ack;
    logic [1:0] eidx;
    ack  = (m_phase == 3) ? 4'(1 << m_owner) : 4'h0;
    eidx = (m_phase == 4) ? 2'(m_owner) : 2'(m_eidx);
    return {(m_phase == 1), (m_phase == 2) && !bus.suspend, (m_phase != 0), (m_phase == 4),
            2'(m_owner), eidx, ack, m_mask};
  endfunction

  task automatic model_step();
    logic [3:0] elig, nmask;
    int nlast, c, start;
    nmask = m_mask & ~bus.mask_clr;
    nlast = -1;
    case (m_phase)
      0: begin
        elig = bus.dma_req & ~m_mask;
        if (m_last >= 0) elig[m_last] = 1'b0;
`ifdef DMAC_ARB_FIXED_PRIO_EN
        start = 0;
`else
        start = m_ptr;
`endif
        c = first_from(elig, start);
        if (c >= 0) begin
          m_owner = c;
          m_phase = 1;
        end
      end
      1: m_phase = 2;
      2: begin
        if (bus.M_HResp == 2'b01) m_phase = 4;
        else if (bus.chan_irq)    m_phase = 3;
      end
      3: begin
        m_ptr   = (m_owner + 1) % N;
        nlast   = m_owner;
        m_phase = 0;
      end
      default: begin
        m_ptr   = (m_owner + 1) % N;
        nmask[m_owner] = 1'b1;
        m_eidx  = m_owner;
        m_phase = 0;
      end
    endcase
    m_mask = nmask;
    m_last = nlast;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, exp_g, seen;
    logic [15:0] e;

    // req, irq, hresp, clr | cfg, en, busy, eirq, grant, eidx, ack, emask
    tbl.push_back(mk(4'h4, 0, 2'b00, 4'h0, 0, 0, 0, 0, 2'd0, 2'd0, 4'h0, 4'h0));
    tbl.push_back(mk(4'h4, 0, 2'b00, 4'h0, 1, 0, 1, 0, 2'd2, 2'd0, 4'h0, 4'h0));
    tbl.push_back(mk(4'h4, 0, 2'b00, 4'h0, 0, 1, 1, 0, 2'd2, 2'd0, 4'h0, 4'h0));
    tbl.push_back(mk(4'h0, 0, 2'b00, 4'h0, 0, 1, 1, 0, 2'd2, 2'd0, 4'h0, 4'h0));
    tbl.push_back(mk(4'h0, 1, 2'b00, 4'h0, 0, 1, 1, 0, 2'd2, 2'd0, 4'h0, 4'h0));
    tbl.push_back(mk(4'h0, 0, 2'b00, 4'h0, 0, 0, 1, 0, 2'd2, 2'd0, 4'h4, 4'h0));
    tbl.push_back(mk(4'h4, 0, 2'b00, 4'h0, 0, 0, 0, 0, 2'd2, 2'd0, 4'h0, 4'h0));
    tbl.push_back(mk(4'h4, 0, 2'b00, 4'h0, 0, 0, 0, 0, 2'd2, 2'd0, 4'h0, 4'h0));
    tbl.push_back(mk(4'h4, 0, 2'b00, 4'h0, 1, 0, 1, 0, 2'd2, 2'd0, 4'h0, 4'h0));
    tbl.push_back(mk(4'h4, 1, 2'b01, 4'h0, 0, 1, 1, 0, 2'd2, 2'd0, 4'h0, 4'h0));
    tbl.push_back(mk(4'h4, 0, 2'b00, 4'h0, 0, 0, 1, 1, 2'd2, 2'd2, 4'h0, 4'h0));
    tbl.push_back(mk(4'h4, 0, 2'b00, 4'h0, 0, 0, 0, 0, 2'd2, 2'd2, 4'h0, 4'h4));
    tbl.push_back(mk(4'h4, 0, 2'b00, 4'h4, 0, 0, 0, 0, 2'd2, 2'd2, 4'h0, 4'h4));
    tbl.push_back(mk(4'h4, 0, 2'b00, 4'h0, 0, 0, 0, 0, 2'd2, 2'd2, 4'h0, 4'h0));
    tbl.push_back(mk(4'h0, 0, 2'b00, 4'h0, 1, 0, 1, 0, 2'd2, 2'd2, 4'h0, 4'h0));
    tbl.push_back(mk(4'h0, 1, 2'b00, 4'h0, 0, 1, 1, 0, 2'd2, 2'd2, 4'h0, 4'h0));
    tbl.push_back(mk(4'h0, 0, 2'b00, 4'h0, 0, 0, 1, 0, 2'd2, 2'd2, 4'h4, 4'h0));

    do_reset();
    foreach (tbl[i]) begin
      @(negedge clk);
      bus.dma_req  = tbl[i].req;
      bus.chan_irq = tbl[i].irq;
      bus.M_HResp  = tbl[i].hresp;
      bus.mask_clr = tbl[i].clr;
      #1 chk($sformatf("vec%0d", i), act_vec(), tbl[i].exp);
    end
    drive_idle();

    // Round-robin with every requester held high.
    do_reset();
    bus.dma_req = 4'hF;
    for (int t = 0; t < 5; t++) begin
`ifdef DMAC_ARB_FIXED_PRIO_EN
      exp_g = t % 2;
`else
      exp_g = t % 4;
`endif
      wait_cfg(g);
      chk("rr_grant", 32'(g), 32'(exp_g));
      @(negedge clk);
      bus.chan_irq = 1'b1;
      @(negedge clk);
      bus.chan_irq = 1'b0;
      #1 chk("rr_ack", 32'(bus.dma_ack), 32'(1 << exp_g));
    end
    drive_idle();

    // Suspend and resume, then completion while suspended.
    do_reset();
    bus.dma_req = 4'h1;
    wait_cfg(g);
    @(negedge clk);
    #1 chk("susp_active_en", 32'(bus.channel_en), 32'd1);
    @(negedge clk);
    bus.suspend = 1'b1;
    #1 chk("susp_en_low", 32'(bus.channel_en), 32'd0);
    chk("susp_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    bus.suspend = 1'b0;
    #1 chk("susp_release_en", 32'(bus.channel_en), 32'd1);
    @(negedge clk);
    bus.suspend  = 1'b1;
    bus.chan_irq = 1'b1;
    #1 chk("susp_irq_en", 32'(bus.channel_en), 32'd0);
    @(negedge clk);
    bus.chan_irq = 1'b0;
    bus.dma_req  = 4'h0;
    #1 chk("susp_ack", 32'(bus.dma_ack), 32'h1);
    drive_idle();

    // Error on requester 3, lockout until mask_clr.
    do_reset();
    bus.dma_req = 4'h8;
    wait_cfg(g);
    chk("err_grant", 32'(g), 32'd3);
    @(negedge clk);
    bus.M_HResp  = 2'b01;
    bus.chan_irq = 1'b1;
    @(negedge clk);
    bus.M_HResp  = 2'b00;
    bus.chan_irq = 1'b0;
    #1 chk("err_irq", 32'(bus.err_irq), 32'd1);
    chk("err_idx", 32'(bus.err_idx), 32'd3);
    chk("err_no_ack", 32'(bus.dma_ack), 32'h0);
    @(negedge clk);
    #1 chk("err_mask", 32'(bus.err_mask), 32'h8);
    chk("err_idx_hold", 32'(bus.err_idx), 32'd3);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1 if (bus.busy) seen++;
    end
    chk("err_locked_out", 32'(seen), 32'd0);
    @(negedge clk);
    bus.mask_clr = 4'h8;
    @(negedge clk);
    bus.mask_clr = 4'h0;
    wait_cfg(g);
    chk("err_regrant", 32'(g), 32'd3);
    drive_idle();

    // Asynchronous reset while the transfer is active.
    do_reset();
    bus.dma_req = 4'h2;
    wait_cfg(g);
    @(negedge clk);
    #1 chk("arst_active_en", 32'(bus.channel_en), 32'd1);
    #2 rst = 1'b1;
    #1 chk("arst_outputs", 32'(act_vec()), 32'h0);
    seen = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1 if (bus.dma_ack != 4'h0 || bus.err_irq) seen++;
    end
    chk("arst_no_pulse", 32'(seen), 32'd0);
    drive_idle();
    rst = 1'b0;

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      bus.dma_req  = 4'($urandom_range(0, 15));
      bus.suspend  = ($urandom_range(0, 3) == 0);
      bus.chan_irq = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 11))
        0:       bus.M_HResp = 2'b01;
        1:       bus.M_HResp = 2'b11;
        2:       bus.M_HResp = 2'b10;
        default: bus.M_HResp = 2'b00;
      endcase
      bus.mask_clr = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      #1;
      e = model_out();
      chk("random", 32'(act_vec()), 32'(e));
      @(posedge clk);
      model_step();
    end
    drive_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
